// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the serial seven-segment scanner.
//   SEG_TABLE  - active-low glyphs for hex digits 0..F (bits 7..1 = a..g, bit 0 = dp)
//   SEG_BLANK  - all segments off
//   SEG_DASH   - only segment g lit (overflow indication)
//   FRAME_W    - bits per digit frame {select[7:0], seg[7:0]}
//   state_t    - capture FSM states
package seg_pkg;

  localparam logic [7:0] SEG_TABLE [0:15] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam int         FRAME_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_WAIT = 2'd2,
    ST_SWAP = 2'd3
  } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, one input bit per cycle.
//   clk, rst - clock, synchronous active-high reset
//   start    - pulse: capture bin and begin a W-cycle conversion
//   bin      - binary input, sampled on start
//   done     - one-cycle pulse when bcd/ovf are final (they hold afterwards)
//   bcd      - DIGITS+1 BCD digits, digit k at [4k+3:4k]
//   ovf      - result needs more than DIGITS decimal digits
module bin2bcd_seq #(
  parameter int W      = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  done,
  output logic [4*DIGITS+3:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4*DIGITS + 4;

  logic [W-1:0]  sh;
  logic [BW-1:0] acc;
  logic [BW-1:0] adj;
  logic [5:0]    cnt;
  logic          busy;
  logic          sticky;

  // Add-3 correction on every digit that is 5 or more before the shift.
  always_comb begin
    adj = acc;
    for (int k = 0; k < DIGITS + 1; k++) begin
      if (acc[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sticky <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh     <= bin;
        acc    <= '0;
        cnt    <= 6'(W);
        busy   <= 1'b1;
        sticky <= 1'b0;
      end else if (busy) begin
        acc    <= {adj[BW-2:0], sh[W-1]};
        sh     <= sh << 1;
        // A bit leaving the top digit means the value exceeds the register.
        sticky <= sticky | adj[BW-1];
        cnt    <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = acc;
  assign ovf = sticky | (acc[BW-1:BW-4] != 4'd0);

endmodule

// File: rtl/seg_scan.sv
// seg_scan: serial seven-segment scanner for a 74HC595-style chain.
//   clk, rst  - clock, synchronous active-high reset
//   val       - binary value, captured on load & ready
//   dp        - per-digit decimal point enable (bit i = digit i)
//   dec       - 0 = hex, 1 = decimal
//   blank_lz  - blank leading zeros (digit 0 always shown)
//   load      - capture request; ready - capture possible
//   ovf       - value currently displayed did not fit
//   ds, shclk, stclk - serial data, shift clock, storage clock
// Handshake: a load is taken in any cycle where load and ready are both 1;
// load while ready is 0 is dropped. ready returns after the new glyphs are
// swapped into the display buffer at a frame boundary, so frames never tear.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int W      = 32,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      val,
  input  logic [DIGITS-1:0] dp,
  input  logic              dec,
  input  logic              blank_lz,
  input  logic              load,
  output logic              ready,
  output logic              ovf,
  output logic              ds,
  output logic              shclk,
  output logic              stclk
);

  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t state, state_next;

  logic [W-1:0]          cap_val;
  logic [DIGITS-1:0]     cap_dp;
  logic                  cap_dec, cap_blz;
  logic                  accept, conv_done, b_start, b_done, b_ovf;
  logic [4*DIGITS+3:0]   b_bcd;
  logic [8*DIGITS-1:0]   glyph_next, gbuf, disp;
  logic                  gbuf_ovf, src_ovf, hex_ovf, seen;
  logic [3:0]            nib;
  logic [7:0]            g;
  logic [CW-1:0]         cyc;
  logic [4:0]            bitc;
  logic [DGW-1:0]        dig;
  logic                  frame_end;
  logic [FRAME_W-1:0]    frame16;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) u_b2b (
    .clk   (clk),
    .rst   (rst),
    .start (b_start),
    .bin   (val),
    .done  (b_done),
    .bcd   (b_bcd),
    .ovf   (b_ovf)
  );

  // ---------------- capture FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    conv_done  = 1'b0;
    ready      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (load) begin
          accept     = 1'b1;
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        if (!cap_dec || b_done) begin
          conv_done  = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: if (frame_end) state_next = ST_SWAP;
      ST_SWAP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The converter sees val directly on the accept cycle, so it starts
  // in parallel with the capture registers.
  assign b_start = accept & dec;

  // ---------------- glyph formatting ----------------
  always_comb begin
    hex_ovf = 1'b0;
    for (int b = 0; b < W; b++) begin
      if (b >= 4*DIGITS && cap_val[b]) hex_ovf = 1'b1;
    end
    // The extra BCD digit is also checked by the converter; folding it in
    // here keeps the overflow decision local and complete.
    src_ovf    = cap_dec ? (b_ovf | (b_bcd[4*DIGITS +: 4] != 4'd0)) : hex_ovf;
    seen       = !cap_blz;
    nib        = '0;
    g          = SEG_BLANK;
    glyph_next = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = '0;
      if (cap_dec) begin
        nib = b_bcd[4*i +: 4];
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (4*i + k < W) nib[k] = cap_val[4*i + k];
        end
      end
      if (nib != 4'd0 || i == 0) seen = 1'b1;
      g = seen ? SEG_TABLE[nib] : SEG_BLANK;
      if (src_ovf)   g = SEG_DASH;
      if (cap_dp[i]) g[0] = 1'b0;
      glyph_next[8*i +: 8] = g;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_val  <= '0;
      cap_dp   <= '0;
      cap_dec  <= 1'b0;
      cap_blz  <= 1'b0;
      gbuf     <= '1;
      gbuf_ovf <= 1'b0;
      disp     <= '1;
      ovf      <= 1'b0;
    end else begin
      if (accept) begin
        cap_val <= val;
        cap_dp  <= dp;
        cap_dec <= dec;
        cap_blz <= blank_lz;
      end
      if (conv_done) begin
        gbuf     <= glyph_next;
        gbuf_ovf <= src_ovf;
      end
      // Swap on the very last storage-clock cycle of the frame so the next
      // frame reads the new buffer from its first bit.
      if (state == ST_WAIT && frame_end) begin
        disp <= gbuf;
        ovf  <= gbuf_ovf;
      end
    end
  end

  // ---------------- scanner ----------------
  assign frame_end = (dig == DGW'(DIGITS - 1)) && (bitc == 5'(FRAME_W)) &&
                     (cyc == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc  <= '0;
      bitc <= '0;
      dig  <= '0;
    end else if (cyc == CW'(DIV - 1)) begin
      cyc <= '0;
      if (bitc == 5'(FRAME_W)) begin
        bitc <= '0;
        dig  <= (dig == DGW'(DIGITS - 1)) ? '0 : dig + 1'b1;
      end else begin
        bitc <= bitc + 5'd1;
      end
    end else begin
      cyc <= cyc + 1'b1;
    end
  end

  assign frame16 = {8'h80 >> dig, disp[8*dig +: 8]};

  // Outputs are registered from the counters: one cycle behind them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ds    <= 1'b0;
      shclk <= 1'b0;
      stclk <= 1'b0;
    end else if (bitc == 5'(FRAME_W)) begin
      ds    <= 1'b0;
      shclk <= 1'b0;
      stclk <= 1'b1;
    end else begin
      ds    <= frame16[bitc[3:0]];
      shclk <= (cyc >= CW'(DIV / 2));
      stclk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;
  localparam int DIGITS    = 8;
  localparam int W         = 32;
  localparam int DIV       = 2;
  localparam int FRAME_CYC = DIGITS * 17 * DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]      val = '0;
  logic [DIGITS-1:0] dp = '0;
  logic              dec = 1'b0, blank_lz = 1'b0, load = 1'b0;
  logic              ready, ovf, ds, shclk, stclk;

  seg_scan #(.DIGITS(DIGITS), .W(W), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .val(val), .dp(dp), .dec(dec),
    .blank_lz(blank_lz), .load(load), .ready(ready), .ovf(ovf),
    .ds(ds), .shclk(shclk), .stclk(stclk)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- serial decoder (display model) ----------------
  logic [15:0] sreg = '0;
  logic [63:0] digs = '0, last_frame = '0;
  int frame_cnt = 0, exp_idx = 0, st_hi = 0, last_rise = -1, cyc_n = 0;
  bit prev_sh = 0, prev_st = 0, in_st = 0;

  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      exp_idx   = 0;
      last_rise = -1;
      in_st     = 0;
      st_hi     = 0;
    end else begin
      if (shclk === 1'b1 && !prev_sh) sreg = {ds, sreg[15:1]};
      if (stclk === 1'b1 && !prev_st) begin
        check("sel_order", {56'd0, sreg[15:8]}, {56'd0, 8'h80 >> exp_idx});
        if (last_rise >= 0) check("st_period", 64'(cyc_n - last_rise), 64'(17 * DIV));
        last_rise = cyc_n;
        digs[8*exp_idx +: 8] = sreg[7:0];
        st_hi = 1;
        in_st = 1;
        if (exp_idx == DIGITS - 1) begin
          last_frame = digs;
          frame_cnt++;
          exp_idx = 0;
        end else begin
          exp_idx++;
        end
      end else if (stclk === 1'b1) begin
        st_hi++;
        check("st_shclk_low", {63'd0, shclk}, 64'd0);
      end
      if (stclk === 1'b0 && prev_st && in_st) begin
        check("st_width", 64'(st_hi), 64'(DIV));
        in_st = 0;
      end
    end
    prev_sh = (shclk === 1'b1);
    prev_st = (stclk === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 2 * FRAME_CYC) begin
      tick();
      n++;
    end
    if (ready !== 1'b1) timeout_fail(name);
  endtask

  task automatic wait_frames(input int n);
    int target = frame_cnt + n;
    int c = 0;
    while (frame_cnt < target && c < n * FRAME_CYC + 100) begin
      tick();
      c++;
    end
    if (frame_cnt < target) timeout_fail("frame_wait");
  endtask

  task automatic pulse_load(input logic [W-1:0] v, input logic [DIGITS-1:0] d,
                            input logic dc, input logic bz);
    val = v; dp = d; dec = dc; blank_lz = bz; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] val;
    logic [7:0]  dp;
    logic        dec;
    logic        blz;
    logic [63:0] exp_frame;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];
  logic [63:0] exp_q[$];
  logic        ovf_q[$];

  initial begin
    logic [63:0] old_f, new_f, e;
    logic        eo;
    int          lat, lim;

    vecs[0] = '{32'h00C0FFEE, 8'h00, 1'b0, 1'b1, 64'hFFFF630371716161, 1'b0};
    vecs[1] = '{32'd1234567,  8'h08, 1'b1, 1'b0, 64'h039F250D9849411F, 1'b0};
    vecs[2] = '{32'd100000000,8'h00, 1'b1, 1'b0, 64'hFDFDFDFDFDFDFDFD, 1'b1};
    vecs[3] = '{32'd0,        8'h00, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFF03, 1'b0};
    vecs[4] = '{32'h12345678, 8'h81, 1'b0, 1'b0, 64'h9E250D9949411F00, 1'b0};
    vecs[5] = '{32'h9ABCDEF0, 8'h00, 1'b0, 1'b1, 64'h0911C16385617103, 1'b0};
    vecs[6] = '{32'd99999999, 8'h00, 1'b1, 1'b1, 64'h0909090909090909, 1'b0};
    vecs[7] = '{32'hFFFFFFFF, 8'h01, 1'b1, 1'b0, 64'hFDFDFDFDFDFDFDFC, 1'b1};
    vecs[8] = '{32'h00000000, 8'h00, 1'b0, 1'b0, 64'h0303030303030303, 1'b0};
    vecs[9] = '{32'd1000,     8'h80, 1'b1, 1'b1, 64'hFEFFFFFF9F030303, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ds",    {63'd0, ds},    64'd0);
    check("rst_shclk", {63'd0, shclk}, 64'd0);
    check("rst_stclk", {63'd0, stclk}, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_ovf",   {63'd0, ovf},   64'd0);
    rst = 1'b0;

    // Idle display after reset is all blank
    wait_frames(2);
    check("idle_frame", last_frame, {8{8'hFF}});

    // Table-driven loads
    foreach (vecs[i]) begin
      wait_ready("ready_before_load");
      exp_q.push_back(vecs[i].exp_frame);
      ovf_q.push_back(vecs[i].exp_ovf);
      pulse_load(vecs[i].val, vecs[i].dp, vecs[i].dec, vecs[i].blz);
      check("ready_drop", {63'd0, ready}, 64'd0);
      lat = 1;
      while (ready !== 1'b1 && lat < 2 * FRAME_CYC) begin
        tick();
        lat++;
      end
      lim = (vecs[i].dec ? W + 1 : 1) + FRAME_CYC + 2;
      check("ready_latency_ok", {63'd0, (lat <= lim)}, 64'd1);
      wait_frames(1);
      e  = exp_q.pop_front();
      eo = ovf_q.pop_front();
      for (int d = 0; d < DIGITS; d++) begin
        check($sformatf("vec%0d_digit%0d", i, d), {56'd0, last_frame[8*d +: 8]}, {56'd0, e[8*d +: 8]});
      end
      check($sformatf("vec%0d_ovf", i), {63'd0, ovf}, {63'd0, eo});
    end

    // Mid-frame load, then a second load while busy: whole frames only,
    // and the second value never appears.
    old_f = vecs[9].exp_frame;
    new_f = {8{8'h9F}};
    wait_frames(1);
    repeat (100) tick();
    pulse_load(32'h11111111, 8'h00, 1'b0, 1'b0);
    check("busy_ready", {63'd0, ready}, 64'd0);
    repeat (3) tick();
    pulse_load(32'h22222222, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_frames(1);
      check("no_tear", {63'd0, (last_frame == old_f || last_frame == new_f)}, 64'd1);
    end
    check("second_load_ignored", last_frame, new_f);
    check("tear_ready_back", {63'd0, ready}, 64'd1);

    // Overflow value on display, then reset in the middle of a decimal conversion
    wait_ready("ready_before_ovf");
    pulse_load(32'd123456789, 8'h00, 1'b1, 1'b0);
    wait_ready("ready_after_ovf");
    wait_frames(1);
    check("pre_abort_ovf", {63'd0, ovf}, 64'd1);
    pulse_load(32'd1234, 8'h00, 1'b1, 1'b1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("abort_ready", {63'd0, ready}, 64'd1);
    check("abort_ovf",   {63'd0, ovf},   64'd0);
    rst = 1'b0;
    wait_frames(2);
    check("abort_blank", last_frame, {8{8'hFF}});
    wait_frames(2);
    check("abort_no_swap", last_frame, {8{8'hFF}});
    check("abort_ready_idle", {63'd0, ready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Parametrised serial seven-segment scanner; the successor of the fixed 8-digit hex display path. It accepts a binary value through a load handshake and converts it to hex or decimal digits, with an iterative binary-to-BCD stage for decimal. It then multiplexes the digits onto a chain of 74HC595-style shift registers. Per-digit decimal points, leading-zero blanking, overflow indication and tear-free frame updates are added. It sits between the measurement logic and the board display pins.

## Interface
Parameters:
- DIGITS, 8: number of displayed digits; legal range 1..8.
- W, 32: input value width; legal range 4..32.
- DIV, 4: clk cycles per shifted bit; even, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- val  in  W  binary value to display.
- dp  in  DIGITS  decimal-point enable per digit; bit i is digit i.
- dec  in  1  mode: 0 = hex, 1 = decimal.
- blank_lz  in  1  blank leading zeros.
- load  in  1  request to capture val/dp/dec/blank_lz; accepted when load & ready.
- ready  out  1  block can accept load.
- ovf  out  1  value currently displayed did not fit in DIGITS digits.
- ds  out  1  serial data to shift-register chain.
- shclk  out  1  shift clock.
- stclk  out  1  storage (latch) clock.

## Operation
- Digit 0 is the least significant digit, and its select byte is 8'h80 >> idx. Idx is the digit index 0..DIGITS-1.
- Each digit frame is 16 bits: {select[7:0], seg[7:0]}, shifted bit 0 first.
- Segment codes are active low: bits 7..1 = a..g and bit 0 = dp. Hex glyphs are 0..F using the shared table ('0' = 8'h03, 'F' = 8'h71). Blank = 8'hFF and dash = 8'hFD. If dp[i] is set, bit 0 of digit i is cleared.
- The capture FSM has four states.
  - IDLE: ready=1; load moves to CONV.
  - CONV: in hex mode, nibbles are taken directly in 1 cycle. In decimal mode, the bin2bcd_seq sub-module runs W cycles of double-dabble.
  - WAIT: holds the converted glyphs until the scanner reaches the last stclk of digit DIGITS-1.
  - SWAP: on that boundary, the glyph buffer and ovf are written to the display buffer, then the FSM returns to IDLE.
- Overflow occurs when, in hex mode, nibbles at index DIGITS and above are nonzero, or in decimal mode, val >= 10^DIGITS. On overflow, all digits are dash and ovf=1. dp still applies.
- Leading-zero blanking: when blank_lz=1, digits above the most significant nonzero digit are blank. Digit 0 is never blanked, so a value of 0 shows '0'.
- The scanner runs continuously, from reset onward, independent of the FSM.

## Timing
- Bit period is DIV cycles.
  - ds changes on the first cycle of the period.
  - shclk is 0 for the first DIV/2 cycles and 1 for the last DIV/2 cycles.
- After 16 bits, stclk=1 for DIV cycles with shclk=0. The next digit then starts.
- Digit period is 17*DIV cycles. Frame period is DIGITS*17*DIV cycles.
- Latency from load to display:
  - CONV lasts 1 cycle (hex) or W+1 cycles (decimal).
  - The new data appears from the digit-0 shift that follows the next frame end.
- ready stays 0 from the cycle after acceptance until the SWAP cycle inclusive. load while ready=0 is ignored.
- Reset values: ds=0, shclk=0, stclk=0, ready=1, ovf=0, display buffer all 8'hFF, scanner at digit 0, bit 0, cycle 0.
- Reset mid-conversion or mid-shift aborts both immediately; no partial swap.
- If a load is accepted in the same cycle as the frame end, it waits for the following frame end.
- val is captured at acceptance; later changes are ignored.

## Structure
- Package seg_pkg holds:
  - the 16-entry segment table;
  - SEG_BLANK, SEG_DASH;
  - the frame width constant 16;
  - an enum for the FSM states.
- Sub-module bin2bcd_seq(clk, rst, start, bin[W-1:0], done, bcd[4*DIGITS+3:0], ovf). It performs iterative shift-add-3, one bit per cycle.
- Top level contains the FSM, glyph formatting, display buffer and scanner counters. The scanner counters are a cycle counter, bit counter and digit counter.

## Test plan
- Reset, DIGITS=8, DIV=2, no load: every frame shifts 8'hFF segments with selects 8'h80..8'h01. stclk pulse width is 2 cycles and occurs every 34 cycles.
- Hex load val=32'h00C0FFEE, dp=0, blank_lz=1: digits 0..5 show E,E,F,F,0,C (8'h61,8'h61,8'h71,8'h71,8'h03,8'h63); digits 6..7 are 8'hFF; ovf=0.
- Decimal load val=1234567, dp=8'h08, blank_lz=0: digits show 7,6,5,4,3,2,1,0. Digit 3 segment is 8'h98; ready returns high within 33 cycles plus one frame.
- Decimal load val=100000000 with DIGITS=8: all digits 8'hFD and ovf=1. A following load of 0 with blank_lz=1 shows digit 0 = 8'h03 and the rest 8'hFF, with ovf=0.
- Load pulsed mid-frame, with a second load while ready=0: no tearing, so all digits within a frame come from one value. The second load is ignored.
- rst asserted during decimal CONV: the next cycle has ready=1 and the display buffer is blank. No swap of the aborted value ever occurs.
